// File: rtl/datactrl_pkg.sv
// Shared constants, state encoding and load-extension helpers for the
// data-memory controller.
package datactrl_pkg;

    localparam int DefAddressWidth = 32;
    localparam int DefIDWidth      = 32;
    localparam int DataStateWidth  = 2;

    typedef enum logic [DataStateWidth-1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } data_state_e;

    localparam logic [2:0] WidthByte = 3'b001;
    localparam logic [2:0] WidthHalf = 3'b010;
    localparam logic [2:0] WidthWord = 3'b100;

    function automatic logic [2:0] width_bytes(input logic [2:0] width);
        case (width)
            WidthByte: width_bytes = 3'd1;
            WidthHalf: width_bytes = 3'd2;
            WidthWord: width_bytes = 3'd4;
            default:   width_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  nbytes,
                                                input logic        sgn);
        case (nbytes)
            3'd1:    extend_load = {{24{sgn & word[7]}}, word[7:0]};
            3'd2:    extend_load = {{16{sgn & word[15]}}, word[15:0]};
            default: extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/datactrl.sv
// Data-memory controller: serialises one load or one committed store at a
// time onto a byte-wide, little-endian memory port.
module datactrl
    import datactrl_pkg::*;
#(
    parameter int AddressWidth = DefAddressWidth,
    parameter int IDWidth      = DefIDWidth
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_datactrl_rst_in,
    input  logic                    lbuffer_datactrl_en_in,
    input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
    input  logic [2:0]              lbuffer_datactrl_width_in,
    input  logic                    lbuffer_datactrl_sgn_in,
    output logic                    datactrl_lbuffer_en_out,
    output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
    input  logic                    sbuffer_datactrl_en_in,
    input  logic [AddressWidth-1:0] sbuffer_datactrl_addr_in,
    input  logic [2:0]              sbuffer_datactrl_width_in,
    input  logic [IDWidth-1:0]      sbuffer_datactrl_data_in,
    output logic                    datactrl_sbuffer_en_out,
    output logic [AddressWidth-1:0] mem_a_out,
    output logic [7:0]              mem_dout_out,
    output logic                    mem_wr_out,
    input  logic [7:0]              mem_din_in
);

    data_state_e             state_r;
    data_state_e             state_nx_s;
    logic [AddressWidth-1:0] addr_r;
    logic [AddressWidth-1:0] addr_nx_s;
    logic [IDWidth-1:0]      sdata_r;
    logic [2:0]              nbytes_r;
    logic [2:0]              cnt_r;
    logic [2:0]              cnt_inc_s;
    logic                    sgn_r;
    logic [31:0]             asm_r;
    logic [31:0]             asm_nx_s;
    logic [7:0]              din_hold_r;
    logic [7:0]              din_s;
    logic                    stalled_r;
    logic [1:0]              byte_idx_s;
    logic [1:0]              st_idx_s;
    logic                    accept_st_s;
    logic                    accept_ld_s;
    logic                    last_s;

    // Next-state and acceptance decode; stores beat loads, flush blocks loads only.
    always_comb begin
        state_nx_s  = state_r;
        accept_st_s = 1'b0;
        accept_ld_s = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (sbuffer_datactrl_en_in) begin
                    accept_st_s = 1'b1;
                    state_nx_s  = STORE;
                end else if (lbuffer_datactrl_en_in && !rob_datactrl_rst_in) begin
                    accept_ld_s = 1'b1;
                    state_nx_s  = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (rob_datactrl_rst_in) begin
                    state_nx_s = IDLE;
                end else if (cnt_r == nbytes_r) begin
                    last_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            STORE: begin
                if (cnt_r == nbytes_r - 3'd1) begin
                    last_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = STORE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Byte steering: next address, read-byte placement and store-byte select.
    always_comb begin
        din_s      = stalled_r ? din_hold_r : mem_din_in;
        cnt_inc_s  = cnt_r + 3'd1;
        addr_nx_s  = addr_r + AddressWidth'(cnt_inc_s);
        byte_idx_s = cnt_r[1:0] - 2'd1;
        st_idx_s   = cnt_inc_s[1:0];
        asm_nx_s   = asm_r;
        asm_nx_s[{byte_idx_s, 3'b000} +: 8] = din_s;
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else if (rdy_in) begin
            state_r <= state_nx_s;
        end
    end

    // Memory keeps answering while rdy_in is low, so park the byte that was
    // due at the first stalled edge and replay it when the stall ends.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stalled_r  <= 1'b0;
            din_hold_r <= 8'd0;
        end else if (!rdy_in) begin
            if (!stalled_r) begin
                din_hold_r <= mem_din_in;
            end
            stalled_r <= 1'b1;
        end else begin
            stalled_r <= 1'b0;
        end
    end

    // Datapath and registered memory/response outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_r                    <= '0;
            sdata_r                   <= '0;
            nbytes_r                  <= 3'd0;
            cnt_r                     <= 3'd0;
            sgn_r                     <= 1'b0;
            asm_r                     <= 32'd0;
            mem_a_out                 <= '0;
            mem_dout_out              <= 8'd0;
            mem_wr_out                <= 1'b0;
            datactrl_lbuffer_en_out   <= 1'b0;
            datactrl_lbuffer_data_out <= '0;
            datactrl_sbuffer_en_out   <= 1'b0;
        end else if (rdy_in) begin
            datactrl_lbuffer_en_out <= 1'b0;
            datactrl_sbuffer_en_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_st_s) begin
                        addr_r       <= sbuffer_datactrl_addr_in;
                        sdata_r      <= sbuffer_datactrl_data_in;
                        nbytes_r     <= width_bytes(sbuffer_datactrl_width_in);
                        cnt_r        <= 3'd0;
                        mem_a_out    <= sbuffer_datactrl_addr_in;
                        mem_dout_out <= sbuffer_datactrl_data_in[7:0];
                        mem_wr_out   <= 1'b1;
                    end else if (accept_ld_s) begin
                        addr_r    <= lbuffer_datactrl_addr_in;
                        nbytes_r  <= width_bytes(lbuffer_datactrl_width_in);
                        sgn_r     <= lbuffer_datactrl_sgn_in;
                        cnt_r     <= 3'd0;
                        asm_r     <= 32'd0;
                        mem_a_out <= lbuffer_datactrl_addr_in;
                    end
                end
                LOAD: begin
                    if (rob_datactrl_rst_in) begin
                        cnt_r <= 3'd0;
                    end else begin
                        if (cnt_r != 3'd0) begin
                            asm_r <= asm_nx_s;
                        end
                        if (last_s) begin
                            cnt_r                     <= 3'd0;
                            datactrl_lbuffer_en_out   <= 1'b1;
                            datactrl_lbuffer_data_out <= IDWidth'(extend_load(asm_nx_s, nbytes_r, sgn_r));
                        end else begin
                            cnt_r <= cnt_inc_s;
                            if (cnt_inc_s < nbytes_r) begin
                                mem_a_out <= addr_nx_s;
                            end
                        end
                    end
                end
                STORE: begin
                    if (last_s) begin
                        cnt_r                   <= 3'd0;
                        mem_wr_out              <= 1'b0;
                        datactrl_sbuffer_en_out <= 1'b1;
                    end else begin
                        cnt_r        <= cnt_inc_s;
                        mem_a_out    <= addr_nx_s;
                        mem_dout_out <= sdata_r[{st_idx_s, 3'b000} +: 8];
                    end
                end
                default: begin
                    cnt_r      <= 3'd0;
                    mem_wr_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datactrl.sv
// Self-checking bench for datactrl: vector table, hand-written corner
// sequences and randomized traffic against a byte-array reference model.
module tb_datactrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rob;
    logic        lb_en, lb_sgn;
    logic [31:0] lb_addr;
    logic [2:0]  lb_width;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        sb_en;
    logic [31:0] sb_addr, sb_data;
    logic [2:0]  sb_width;
    logic        st_done;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_wr;

    logic        poke_en = 1'b0;
    logic [11:0] poke_a = 12'd0;
    logic [7:0]  poke_d = 8'd0;

    bit [7:0] mem [4096];
    bit [7:0] ref_mem [4096];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  width;
        logic        sgn;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t tab [9];

    always #5 clk = ~clk;

    datactrl #(.AddressWidth(32), .IDWidth(32)) dut (
        .clk_in                    (clk),
        .rst_in                    (rst),
        .rdy_in                    (rdy),
        .rob_datactrl_rst_in       (rob),
        .lbuffer_datactrl_en_in    (lb_en),
        .lbuffer_datactrl_addr_in  (lb_addr),
        .lbuffer_datactrl_width_in (lb_width),
        .lbuffer_datactrl_sgn_in   (lb_sgn),
        .datactrl_lbuffer_en_out   (ld_done),
        .datactrl_lbuffer_data_out (ld_data),
        .sbuffer_datactrl_en_in    (sb_en),
        .sbuffer_datactrl_addr_in  (sb_addr),
        .sbuffer_datactrl_width_in (sb_width),
        .sbuffer_datactrl_data_in  (sb_data),
        .datactrl_sbuffer_en_out   (st_done),
        .mem_a_out                 (mem_a),
        .mem_dout_out              (mem_dout),
        .mem_wr_out                (mem_wr),
        .mem_din_in                (mem_din)
    );

    // Byte RAM: address in cycle c, data in cycle c+1; 4 KiB aliasing.
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
        mem_din <= mem[mem_a[11:0]];
    end

    always @(negedge clk) begin
        if (lb_en) assert (lb_width == 3'b001 || lb_width == 3'b010 || lb_width == 3'b100)
            else $error("illegal load width %b", lb_width);
        if (sb_en) assert (sb_width == 3'b001 || sb_width == 3'b010 || sb_width == 3'b100)
            else $error("illegal store width %b", sb_width);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int nb_of(input logic [2:0] w);
        return (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic s);
        longint v = 0;
        logic [31:0] ad;
        for (int k = 0; k < nb; k++) begin
            ad = a + 32'(k);
            v = v + (longint'(ref_mem[ad[11:0]]) << (8 * k));
        end
        if (s && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_a = a[11:0]; poke_d = d;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a[11:0]] = d;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] w, input logic s,
                           input logic [31:0] exp);
        int nb;
        bit got;
        nb = nb_of(w);
        got = 1'b0;
        @(negedge clk);
        lb_en = 1'b1; lb_addr = a; lb_width = w; lb_sgn = s;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (n <= nb) begin
                check("ld_addr", mem_a, a + 32'(n - 1));
                check("ld_wr", 32'(mem_wr), 32'd0);
            end
            if (ld_done) begin
                got = 1'b1;
                lb_en = 1'b0;
                check("ld_latency", 32'(n), 32'(nb + 2));
                check("ld_data", ld_data, exp);
            end
        end
        lb_en = 1'b0;
        check("ld_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("ld_pulse_once", 32'(ld_done), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d,
                            input logic fl);
        int nb;
        logic [31:0] ad;
        nb = nb_of(w);
        @(negedge clk);
        sb_en = 1'b1; sb_addr = a; sb_width = w; sb_data = d; rob = fl;
        for (int n = 1; n <= nb; n++) begin
            @(negedge clk);
            ad = a + 32'(n - 1);
            check("st_wr", 32'(mem_wr), 32'd1);
            check("st_addr", mem_a, ad);
            check("st_byte", 32'(mem_dout), 32'(d[8*(n-1) +: 8]));
            check("st_early_done", 32'(st_done), 32'd0);
            ref_mem[ad[11:0]] = d[8*(n-1) +: 8];
        end
        @(negedge clk);
        check("st_done", 32'(st_done), 32'd1);
        check("st_wr_off", 32'(mem_wr), 32'd0);
        sb_en = 1'b0; rob = 1'b0;
        @(negedge clk);
        check("st_pulse_once", 32'(st_done), 32'd0);
    endtask

    initial begin
        int st_cyc, ld_cyc, pulses;
        bit overlap;
        logic [31:0] ld_val, a, d;
        logic [2:0] w;
        logic s;

        rst = 1'b1; rdy = 1'b1; rob = 1'b0;
        lb_en = 1'b0; lb_addr = 32'd0; lb_width = 3'b001; lb_sgn = 1'b0;
        sb_en = 1'b0; sb_addr = 32'd0; sb_width = 3'b001; sb_data = 32'd0;

        tab[0] = '{32'h0000_0100, 3'b100, 1'b0, 32'h1234_5678, 32'h1234_5678};
        tab[1] = '{32'h0000_0020, 3'b001, 1'b1, 32'h0000_0080, 32'hFFFF_FF80};
        tab[2] = '{32'h0000_0020, 3'b001, 1'b0, 32'h0000_0080, 32'h0000_0080};
        tab[3] = '{32'h0000_0040, 3'b010, 1'b1, 32'h0000_7FFF, 32'h0000_7FFF};
        tab[4] = '{32'h0000_0044, 3'b010, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
        tab[5] = '{32'h0000_0048, 3'b010, 1'b0, 32'h0000_FFFE, 32'h0000_FFFE};
        tab[6] = '{32'h0000_0050, 3'b100, 1'b1, 32'h8000_0001, 32'h8000_0001};
        tab[7] = '{32'hFFFF_FFFE, 3'b100, 1'b0, 32'hA1B2_C3D4, 32'hA1B2_C3D4};
        tab[8] = '{32'h0000_0061, 3'b001, 1'b1, 32'h0000_007F, 32'h0000_007F};

        repeat (3) @(negedge clk);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_st_done", 32'(st_done), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 4; k++) poke(tab[i].addr + 32'(k), tab[i].word[8*k +: 8]);
            do_load(tab[i].addr, tab[i].width, tab[i].sgn, tab[i].exp);
        end

        // halfword store then read back the word
        do_store(32'h200, 3'b010, 32'hAABB_CCDD, 1'b0);
        do_load(32'h200, 3'b100, 1'b0, ref_load(32'h200, 4, 1'b0));

        // simultaneous store and load: store first, load follows at store-done edge
        @(negedge clk);
        sb_en = 1'b1; sb_addr = 32'h300; sb_width = 3'b100; sb_data = 32'hCAFE_BABE;
        lb_en = 1'b1; lb_addr = 32'h302; lb_width = 3'b010; lb_sgn = 1'b1;
        st_cyc = 0; ld_cyc = 0; overlap = 1'b0; ld_val = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (st_done && ld_done) overlap = 1'b1;
            if (st_done) begin st_cyc = n; sb_en = 1'b0; end
            if (ld_done) begin ld_cyc = n; lb_en = 1'b0; ld_val = ld_data; end
        end
        sb_en = 1'b0; lb_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[12'h300 + 12'(k)] = sb_data[8*k +: 8];
        check("both_st_cycle", 32'(st_cyc), 32'd5);
        check("both_ld_cycle", 32'(ld_cyc), 32'd9);
        check("both_ld_data", ld_val, 32'hFFFF_CAFE);
        check("both_overlap", 32'(overlap), 32'd0);

        // flush in cycle 3 of a word load
        @(negedge clk);
        lb_en = 1'b1; lb_addr = 32'h100; lb_width = 3'b100; lb_sgn = 1'b0;
        repeat (3) @(negedge clk);
        rob = 1'b1;
        @(negedge clk);
        rob = 1'b0; lb_en = 1'b0;
        check("flush_a_held", mem_a, 32'h102);
        pulses = ld_done ? 1 : 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ld_done) pulses++;
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_a_idle", mem_a, 32'h102);
        do_load(32'h20, 3'b001, 1'b1, 32'hFFFF_FF80);

        // flush while idle blocks a load for that edge only
        @(negedge clk);
        lb_en = 1'b1; lb_addr = 32'h20; lb_width = 3'b001; lb_sgn = 1'b0; rob = 1'b1;
        ld_cyc = 0; ld_val = 32'd0;
        for (int n = 1; n <= 12 && ld_cyc == 0; n++) begin
            @(negedge clk);
            rob = 1'b0;
            if (ld_done) begin ld_cyc = n; ld_val = ld_data; lb_en = 1'b0; end
        end
        lb_en = 1'b0;
        check("idle_flush_cycle", 32'(ld_cyc), 32'd4);
        check("idle_flush_data", ld_val, 32'h0000_0080);

        // flush during a store is ignored
        do_store(32'h210, 3'b100, 32'h0102_0304, 1'b1);
        do_load(32'h210, 3'b100, 1'b0, 32'h0102_0304);

        // rdy low for three edges mid word load
        @(negedge clk);
        lb_en = 1'b1; lb_addr = 32'h100; lb_width = 3'b100; lb_sgn = 1'b0;
        ld_cyc = 0; ld_val = 32'd0;
        for (int n = 1; n <= 20 && ld_cyc == 0; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 5) begin
                check("stall_mem_a", mem_a, 32'h101);
                check("stall_no_done", 32'(ld_done), 32'd0);
            end
            if (n == 2) rdy = 1'b0;
            if (n == 5) rdy = 1'b1;
            if (ld_done) begin ld_cyc = n; ld_val = ld_data; lb_en = 1'b0; end
        end
        lb_en = 1'b0; rdy = 1'b1;
        check("stall_cycle", 32'(ld_cyc), 32'd9);
        check("stall_data", ld_val, 32'h1234_5678);

        // reset aborts a store mid-write
        @(negedge clk);
        sb_en = 1'b1; sb_addr = 32'h800; sb_width = 3'b100; sb_data = 32'h5566_7788;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_wr", 32'(mem_wr), 32'd0);
        check("rst_abort_done", 32'(st_done), 32'd0);
        check("rst_abort_a", mem_a, 32'd0);
        check("rst_abort_data", ld_data, 32'd0);
        rst = 1'b0; sb_en = 1'b0;
        ref_mem[12'h800] = 8'h88;
        ref_mem[12'h801] = 8'h77;
        do_load(32'h100, 3'b100, 1'b0, 32'h1234_5678);

        // randomized traffic against the reference byte array
        for (int i = 0; i < 40; i++) begin
            a = 32'h400 + 32'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: w = 3'b001;
                1: w = 3'b010;
                default: w = 3'b100;
            endcase
            s = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) do_store(a, w, d, 1'b0);
            else do_load(a, w, s, ref_load(a, nb_of(w), s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
